// File: rtl/wb_b3_defs.sv
// -----------------------------------------------------------------------------
// wb_b3_defs
// Shared Wishbone B3 definitions for masters and slaves on the B3 bus:
//   - CTI_* : cycle type identifier codes (wb_cti)
//   - BTE_* : burst type extension codes (wb_bte)
//   - wrap_mask() : low-order word-address bits that wrap for a given BTE
// -----------------------------------------------------------------------------
package wb_b3_defs;

   localparam logic [2:0] CTI_CLASSIC = 3'b000;
   localparam logic [2:0] CTI_CONST   = 3'b001;
   localparam logic [2:0] CTI_INCR    = 3'b010;
   localparam logic [2:0] CTI_EOB     = 3'b111;

   localparam logic [1:0] BTE_LINEAR = 2'b00;
   localparam logic [1:0] BTE_WRAP4  = 2'b01;
   localparam logic [1:0] BTE_WRAP8  = 2'b10;
   localparam logic [1:0] BTE_WRAP16 = 2'b11;

   // Word-address bits that increment modulo the wrap length; bits above the
   // mask are held. Linear bursts return 0 (nothing wraps).
   function automatic logic [3:0] wrap_mask(input logic [1:0] bte);
      logic [3:0] mask;
      case (bte)
         BTE_WRAP4:  mask = 4'h3;
         BTE_WRAP8:  mask = 4'h7;
         BTE_WRAP16: mask = 4'hf;
         default:    mask = 4'h0;
      endcase
      return mask;
   endfunction

endpackage

// File: rtl/wb_ram_sp.sv
// -----------------------------------------------------------------------------
// wb_ram_sp
// Single-port synchronous RAM with byte write enables, write-first behaviour
// and a registered read port. Contents are not reset.
//   clk_i    : clock
//   en_i     : port enable; read data register only updates when set
//   be_i     : byte write enables (all zero = read)
//   addr_i   : word address
//   wdata_i  : write data
//   rdata_o  : registered read data (new data when written the same cycle)
// -----------------------------------------------------------------------------
module wb_ram_sp #(
   parameter int unsigned DATA_WIDTH = 32,
   parameter int unsigned WORD_AW    = 13
) (
   input  logic                      clk_i,
   input  logic                      en_i,
   input  logic [DATA_WIDTH/8-1:0]   be_i,
   input  logic [WORD_AW-1:0]        addr_i,
   input  logic [DATA_WIDTH-1:0]     wdata_i,
   output logic [DATA_WIDTH-1:0]     rdata_o
);

   localparam int unsigned SEL_WIDTH = DATA_WIDTH / 8;
   localparam int unsigned DEPTH     = 2 ** WORD_AW;

   logic [DATA_WIDTH-1:0] mem [DEPTH];
   logic [DATA_WIDTH-1:0] rdata_q;
   logic [DATA_WIDTH-1:0] merged;

   // Stored word with the enabled bytes replaced; this is what the read port
   // returns on a write cycle.
   always_comb begin
      merged = mem[addr_i];
      for (int i = 0; i < SEL_WIDTH; i++) begin
         if (be_i[i]) begin
            merged[8*i +: 8] = wdata_i[8*i +: 8];
         end
      end
   end

   always_ff @(posedge clk_i) begin
      if (en_i) begin
         for (int i = 0; i < SEL_WIDTH; i++) begin
            if (be_i[i]) begin
               mem[addr_i][8*i +: 8] <= wdata_i[8*i +: 8];
            end
         end
         rdata_q <= merged;
      end
   end

   assign rdata_o = rdata_q;

endmodule

// File: rtl/wb_sram_burst_slave.sv
// -----------------------------------------------------------------------------
// wb_sram_burst_slave
// Wishbone B3 slave fronting a single-port synchronous SRAM. Serves classic
// single cycles (two clocks per transfer) and registered-feedback incrementing
// bursts (linear, wrap4/8/16) at one beat per clock. Out-of-range accesses end
// with a one-cycle bus error.
//   clk_i              : clock, rising edge
//   rst_i              : synchronous active-high reset
//   wb_adr_i           : byte address (low clog2(SEL_WIDTH) bits ignored)
//   wb_dat_i / wb_dat_o: write data / read data (zero unless acking)
//   wb_cyc_i, wb_stb_i, wb_we_i, wb_sel_i, wb_cti_i, wb_bte_i : B3 request
//   wb_ack_o, wb_err_o : termination; wb_rty_o tied low
// -----------------------------------------------------------------------------
module wb_sram_burst_slave
   import wb_b3_defs::*;
#(
   parameter int unsigned DATA_WIDTH     = 32,
   parameter int unsigned ADDR_WIDTH     = 32,
   parameter int unsigned MEM_SIZE_BYTES = 32768
) (
   input  logic                    clk_i,
   input  logic                    rst_i,
   input  logic [ADDR_WIDTH-1:0]   wb_adr_i,
   input  logic [DATA_WIDTH-1:0]   wb_dat_i,
   input  logic                    wb_cyc_i,
   input  logic                    wb_stb_i,
   input  logic                    wb_we_i,
   input  logic [DATA_WIDTH/8-1:0] wb_sel_i,
   input  logic [2:0]              wb_cti_i,
   input  logic [1:0]              wb_bte_i,
   output logic [DATA_WIDTH-1:0]   wb_dat_o,
   output logic                    wb_ack_o,
   output logic                    wb_err_o,
   output logic                    wb_rty_o
);

   localparam int unsigned SEL_WIDTH = DATA_WIDTH / 8;
   localparam int unsigned ADDR_LSB  = $clog2(SEL_WIDTH);
   localparam int unsigned WORD_AW   = $clog2(MEM_SIZE_BYTES / SEL_WIDTH);

   typedef enum logic [1:0] {
      StIdle,
      StClassicAck,
      StBurst
   } state_e;

   state_e               state_q, state_d;
   logic                 ack_q, ack_d;
   logic                 err_q, err_d;
   logic [WORD_AW-1:0]   addr_q, addr_d;

   logic                 ram_en;
   logic [SEL_WIDTH-1:0] ram_be;
   logic [WORD_AW-1:0]   ram_addr;
   logic [DATA_WIDTH-1:0] ram_rdata;

   logic                 valid;
   logic                 in_range;
   logic [WORD_AW-1:0]   adr_word;
   logic                 addr_match;
   logic [WORD_AW-1:0]   mask;
   logic [WORD_AW:0]     incr;
   logic                 linear;
   logic [WORD_AW-1:0]   next_addr;
   logic                 next_oob;
   logic                 beat_ok;

   // ---------------------------------------------------------------------------
   // Request decode
   // ---------------------------------------------------------------------------
   assign valid    = wb_cyc_i & wb_stb_i;
   assign adr_word = wb_adr_i[ADDR_LSB +: WORD_AW];
   assign in_range = (wb_adr_i[ADDR_WIDTH-1:ADDR_LSB+WORD_AW] == '0);

   // A burst beat is only taken when the master presents the address we expect.
   assign addr_match = in_range && (adr_word == addr_q);

   generate
      if (ADDR_LSB > 0) begin : g_unused_lsb
         logic unused_adr_lsb;
         assign unused_adr_lsb = ^wb_adr_i[ADDR_LSB-1:0];
      end
   endgenerate

   // ---------------------------------------------------------------------------
   // Next burst address
   // ---------------------------------------------------------------------------
   assign linear = (wb_bte_i == BTE_LINEAR);
   assign mask   = WORD_AW'(wrap_mask(wb_bte_i));
   assign incr   = {1'b0, addr_q} + {{WORD_AW{1'b0}}, 1'b1};

   always_comb begin
      next_addr = '0;
      if (linear) begin
         next_addr = incr[WORD_AW-1:0];
      end else begin
         next_addr = (addr_q & ~mask) | (incr[WORD_AW-1:0] & mask);
      end
   end

   // Only a linear burst can run off the end; wrap blocks stay aligned inside.
   assign next_oob = linear & incr[WORD_AW];

   // ---------------------------------------------------------------------------
   // FSM state register
   // ---------------------------------------------------------------------------
   always_ff @(posedge clk_i) begin
      if (rst_i) begin
         state_q <= StIdle;
         ack_q   <= 1'b0;
         err_q   <= 1'b0;
         addr_q  <= '0;
      end else begin
         state_q <= state_d;
         ack_q   <= ack_d;
         err_q   <= err_d;
         addr_q  <= addr_d;
      end
   end

   // ---------------------------------------------------------------------------
   // FSM next state and RAM port control
   // ---------------------------------------------------------------------------
   always_comb begin
      state_d  = state_q;
      ack_d    = 1'b0;
      err_d    = 1'b0;
      addr_d   = addr_q;
      ram_en   = 1'b0;
      ram_be   = '0;
      ram_addr = addr_q;

      unique case (state_q)
         StIdle: begin
            if (valid) begin
               if (in_range) begin
                  // Read issued now so data is registered for the ack cycle.
                  ram_en   = 1'b1;
                  ram_addr = adr_word;
                  addr_d   = adr_word;
                  ack_d    = 1'b1;
                  state_d  = (wb_cti_i == CTI_INCR) ? StBurst : StClassicAck;
               end else begin
                  err_d   = 1'b1;
                  state_d = StClassicAck;
               end
            end
         end

         // Single ack or err cycle; also used to terminate a burst with err.
         StClassicAck: begin
            state_d = StIdle;
            if (ack_q && valid && wb_we_i) begin
               ram_en = 1'b1;
               ram_be = wb_sel_i;
            end
         end

         StBurst: begin
            if (!wb_cyc_i) begin
               state_d = StIdle;
            end else if (!wb_stb_i) begin
               // Wait state from the master: hold address and prefetched data.
               ack_d = ack_q;
            end else if (!addr_match) begin
               // Master broke the address sequence; re-decode from idle.
               state_d = StIdle;
            end else begin
               if (wb_we_i) begin
                  ram_en = 1'b1;
                  ram_be = wb_sel_i;
               end
               if (wb_cti_i != CTI_INCR) begin
                  state_d = StIdle;
               end else if (next_oob) begin
                  err_d   = 1'b1;
                  state_d = StClassicAck;
               end else begin
                  addr_d = next_addr;
                  ack_d  = 1'b1;
                  // The single port serves either the write of this beat or
                  // the prefetch of the next; a burst keeps one direction.
                  if (!wb_we_i) begin
                     ram_en   = 1'b1;
                     ram_addr = next_addr;
                  end
               end
            end
         end

         default: begin
            state_d = StIdle;
         end
      endcase

      // Nothing reaches the array on a reset cycle, even mid-burst.
      if (rst_i) begin
         ram_en = 1'b0;
         ram_be = '0;
      end
   end

   // ---------------------------------------------------------------------------
   // RAM
   // ---------------------------------------------------------------------------
   wb_ram_sp #(
      .DATA_WIDTH (DATA_WIDTH),
      .WORD_AW    (WORD_AW)
   ) u_ram (
      .clk_i   (clk_i),
      .en_i    (ram_en),
      .be_i    (ram_be),
      .addr_i  (ram_addr),
      .wdata_i (wb_dat_i),
      .rdata_o (ram_rdata)
   );

   // ---------------------------------------------------------------------------
   // Bus outputs
   // ---------------------------------------------------------------------------
   // In a burst the ack is withheld on a beat whose address does not match.
   assign beat_ok  = (state_q != StBurst) || addr_match;
   assign wb_ack_o = ack_q & valid & beat_ok;
   assign wb_err_o = err_q & valid;
   assign wb_rty_o = 1'b0;
   assign wb_dat_o = wb_ack_o ? ram_rdata : '0;

endmodule

// File: tb/tb_wb_sram_burst_slave.sv
module tb_wb_sram_burst_slave;
   import wb_b3_defs::*;

   logic        clk = 1'b0;
   logic        rst = 1'b1;
   logic [31:0] adr = '0;
   logic [31:0] dat_w = '0;
   logic        cyc = 1'b0;
   logic        stb = 1'b0;
   logic        we = 1'b0;
   logic [3:0]  sel = '0;
   logic [2:0]  cti = CTI_CLASSIC;
   logic [1:0]  bte = BTE_LINEAR;
   logic [31:0] dat_r;
   logic        ack;
   logic        err;
   logic        rty;

   int n_assert = 0;
   int n_fail   = 0;

   always #5 clk = ~clk;

   wb_sram_burst_slave #(
      .DATA_WIDTH     (32),
      .ADDR_WIDTH     (32),
      .MEM_SIZE_BYTES (32768)
   ) dut (
      .clk_i    (clk),
      .rst_i    (rst),
      .wb_adr_i (adr),
      .wb_dat_i (dat_w),
      .wb_cyc_i (cyc),
      .wb_stb_i (stb),
      .wb_we_i  (we),
      .wb_sel_i (sel),
      .wb_cti_i (cti),
      .wb_bte_i (bte),
      .wb_dat_o (dat_r),
      .wb_ack_o (ack),
      .wb_err_o (err),
      .wb_rty_o (rty)
   );

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic drive(input logic c, input logic s, input logic w, input logic [31:0] a,
                        input logic [31:0] d, input logic [3:0] be, input logic [2:0] ct,
                        input logic [1:0] bt);
      cyc = c; stb = s; we = w; adr = a; dat_w = d; sel = be; cti = ct; bte = bt;
   endtask

   task automatic bus_idle();
      drive(1'b0, 1'b0, 1'b0, 32'h0, 32'h0, 4'h0, CTI_CLASSIC, BTE_LINEAR);
   endtask

   // Classic cycle: request in cycle 0, ack/err sampled in cycle 1, inputs held
   // through the end of cycle 1 so a write commits.
   task automatic classic(input logic w, input logic [31:0] a, input logic [31:0] d,
                          input logic [3:0] be, output logic o_ack, output logic o_err,
                          output logic [31:0] o_dat);
      drive(1'b1, 1'b1, w, a, d, be, CTI_CLASSIC, BTE_LINEAR);
      tick();
      @(negedge clk);
      o_ack = ack; o_err = err; o_dat = dat_r;
      tick();
      bus_idle();
   endtask

   task automatic test_reset();
      rst = 1'b1;
      bus_idle();
      repeat (3) tick();
      rst = 1'b0;
      @(negedge clk);
      n_assert++; if (ack !== 1'b0) begin n_fail++; $display("FAIL reset_ack got %b want 0", ack); end
      n_assert++; if (err !== 1'b0) begin n_fail++; $display("FAIL reset_err got %b want 0", err); end
      n_assert++; if (rty !== 1'b0) begin n_fail++; $display("FAIL reset_rty got %b want 0", rty); end
      n_assert++; if (dat_r !== 32'h0) begin n_fail++; $display("FAIL reset_dat got %h want 0", dat_r); end
      tick();
   endtask

   task automatic test_classic();
      logic a, e;
      logic [31:0] d;
      logic [3:0] acks;
      classic(1'b1, 32'h10, 32'hDEADBEEF, 4'hF, a, e, d);
      n_assert++; if (a !== 1'b1) begin n_fail++; $display("FAIL classic_wr_ack got %b want 1", a); end
      n_assert++; if (e !== 1'b0) begin n_fail++; $display("FAIL classic_wr_err got %b want 0", e); end
      classic(1'b0, 32'h10, 32'h0, 4'h0, a, e, d);
      n_assert++; if (a !== 1'b1) begin n_fail++; $display("FAIL classic_rd_ack got %b want 1", a); end
      n_assert++; if (d !== 32'hDEADBEEF) begin n_fail++; $display("FAIL classic_rd_dat got %h want deadbeef", d); end
      // stb held for cycles 0..2 must yield a single ack, in cycle 1
      acks = '0;
      drive(1'b1, 1'b1, 1'b0, 32'h10, 32'h0, 4'h0, CTI_CLASSIC, BTE_LINEAR);
      for (int c = 0; c < 4; c++) begin
         if (c == 3) bus_idle();
         @(negedge clk);
         acks[c] = ack;
         tick();
      end
      n_assert++; if (acks !== 4'b0010) begin n_fail++; $display("FAIL classic_held_stb acks got %b want 0010", acks); end
   endtask

   task automatic test_byte_enable();
      logic a, e;
      logic [31:0] d;
      classic(1'b1, 32'h20, 32'h11223344, 4'hF, a, e, d);
      classic(1'b1, 32'h20, 32'hAABBCCDD, 4'b0101, a, e, d);
      classic(1'b0, 32'h20, 32'h0, 4'h0, a, e, d);
      n_assert++; if (d !== 32'h11BB33DD) begin n_fail++; $display("FAIL byte_enable got %h want 11bb33dd", d); end
   endtask

   task automatic test_linear_burst();
      logic a, e;
      logic [31:0] d;
      for (int i = 0; i < 8; i++) begin
         classic(1'b1, 32'h100 + 32'(4*i), 32'hC0DE0000 | (32'h100 + 32'(4*i)), 4'hF, a, e, d);
      end
      drive(1'b1, 1'b1, 1'b0, 32'h100, 32'h0, 4'h0, CTI_INCR, BTE_LINEAR);
      tick();
      for (int k = 0; k < 8; k++) begin
         drive(1'b1, 1'b1, 1'b0, 32'h100 + 32'(4*k), 32'h0, 4'h0,
               (k == 7) ? CTI_EOB : CTI_INCR, BTE_LINEAR);
         @(negedge clk);
         n_assert++;
         if (ack !== 1'b1) begin n_fail++; $display("FAIL lin_burst_ack beat %0d got %b want 1", k + 1, ack); end
         n_assert++;
         if (dat_r !== (32'hC0DE0000 | (32'h100 + 32'(4*k)))) begin
            n_fail++;
            $display("FAIL lin_burst_dat beat %0d got %h want %h", k + 1, dat_r,
                     32'hC0DE0000 | (32'h100 + 32'(4*k)));
         end
         tick();
      end
      drive(1'b1, 1'b1, 1'b0, 32'h120, 32'h0, 4'h0, CTI_EOB, BTE_LINEAR);
      @(negedge clk);
      n_assert++; if (ack !== 1'b0) begin n_fail++; $display("FAIL lin_burst_after_eob ack got %b want 0", ack); end
      tick();
      bus_idle();
      tick();
   endtask

   task automatic test_wrap4();
      logic a, e;
      logic [31:0] d;
      logic [31:0] seq [4];
      seq[0] = 32'h0C; seq[1] = 32'h00; seq[2] = 32'h04; seq[3] = 32'h08;
      for (int i = 0; i < 4; i++) begin
         classic(1'b1, 32'(4*i), 32'h5A5A0000 | 32'(4*i), 4'hF, a, e, d);
      end
      drive(1'b1, 1'b1, 1'b0, 32'h0C, 32'h0, 4'h0, CTI_INCR, BTE_WRAP4);
      tick();
      for (int k = 0; k < 4; k++) begin
         if (k == 2) begin
            for (int p = 0; p < 2; p++) begin
               drive(1'b1, 1'b0, 1'b0, seq[2], 32'h0, 4'h0, CTI_INCR, BTE_WRAP4);
               @(negedge clk);
               n_assert++;
               if (ack !== 1'b0) begin n_fail++; $display("FAIL wrap_pause_ack cyc %0d got %b want 0", p, ack); end
               tick();
            end
         end
         drive(1'b1, 1'b1, 1'b0, seq[k], 32'h0, 4'h0, (k == 3) ? CTI_EOB : CTI_INCR, BTE_WRAP4);
         @(negedge clk);
         n_assert++;
         if (ack !== 1'b1) begin n_fail++; $display("FAIL wrap_ack beat %0d got %b want 1", k + 1, ack); end
         n_assert++;
         if (dat_r !== (32'h5A5A0000 | seq[k])) begin
            n_fail++;
            $display("FAIL wrap_dat beat %0d got %h want %h", k + 1, dat_r, 32'h5A5A0000 | seq[k]);
         end
         tick();
      end
      bus_idle();
      @(negedge clk);
      n_assert++; if (ack !== 1'b0) begin n_fail++; $display("FAIL wrap_after_eob ack got %b want 0", ack); end
      tick();
   endtask

   task automatic test_errors();
      logic a, e;
      logic [31:0] d;
      classic(1'b0, 32'h8000, 32'h0, 4'h0, a, e, d);
      n_assert++; if (e !== 1'b1) begin n_fail++; $display("FAIL oob_classic_err got %b want 1", e); end
      n_assert++; if (a !== 1'b0) begin n_fail++; $display("FAIL oob_classic_ack got %b want 0", a); end
      classic(1'b1, 32'h7FFC, 32'h01020304, 4'hF, a, e, d);
      drive(1'b1, 1'b1, 1'b1, 32'h7FFC, 32'hAAAA0001, 4'hF, CTI_INCR, BTE_LINEAR);
      tick();
      @(negedge clk);
      n_assert++; if (ack !== 1'b1) begin n_fail++; $display("FAIL oob_burst_b1_ack got %b want 1", ack); end
      n_assert++; if (err !== 1'b0) begin n_fail++; $display("FAIL oob_burst_b1_err got %b want 0", err); end
      tick();
      drive(1'b1, 1'b1, 1'b1, 32'h8000, 32'hBBBB0002, 4'hF, CTI_EOB, BTE_LINEAR);
      @(negedge clk);
      n_assert++; if (err !== 1'b1) begin n_fail++; $display("FAIL oob_burst_b2_err got %b want 1", err); end
      n_assert++; if (ack !== 1'b0) begin n_fail++; $display("FAIL oob_burst_b2_ack got %b want 0", ack); end
      tick();
      bus_idle();
      tick();
      classic(1'b0, 32'h7FFC, 32'h0, 4'h0, a, e, d);
      n_assert++; if (d !== 32'hAAAA0001) begin n_fail++; $display("FAIL oob_burst_last_word got %h want aaaa0001", d); end
      classic(1'b0, 32'h0, 32'h0, 4'h0, a, e, d);
      n_assert++; if (d !== 32'h5A5A0000) begin n_fail++; $display("FAIL oob_burst_alias got %h want 5a5a0000", d); end
   endtask

   task automatic test_abort();
      logic a, e;
      logic [31:0] d;
      for (int i = 0; i < 3; i++) begin
         classic(1'b1, 32'h200 + 32'(4*i), 32'h33330200 + 32'(4*i), 4'hF, a, e, d);
      end
      classic(1'b1, 32'h300, 32'h33330300, 4'hF, a, e, d);
      classic(1'b1, 32'h304, 32'h33330304, 4'hF, a, e, d);
      // cyc dropped after two write beats
      drive(1'b1, 1'b1, 1'b1, 32'h200, 32'h44440200, 4'hF, CTI_INCR, BTE_LINEAR);
      tick();
      @(negedge clk);
      n_assert++; if (ack !== 1'b1) begin n_fail++; $display("FAIL abort_b1_ack got %b want 1", ack); end
      tick();
      drive(1'b1, 1'b1, 1'b1, 32'h204, 32'h44440204, 4'hF, CTI_INCR, BTE_LINEAR);
      @(negedge clk);
      n_assert++; if (ack !== 1'b1) begin n_fail++; $display("FAIL abort_b2_ack got %b want 1", ack); end
      tick();
      drive(1'b0, 1'b0, 1'b1, 32'h208, 32'h44440208, 4'hF, CTI_INCR, BTE_LINEAR);
      @(negedge clk);
      n_assert++; if (ack !== 1'b0) begin n_fail++; $display("FAIL abort_drop_ack got %b want 0", ack); end
      tick();
      bus_idle();
      @(negedge clk);
      n_assert++; if (ack !== 1'b0) begin n_fail++; $display("FAIL abort_after_ack got %b want 0", ack); end
      tick();
      classic(1'b0, 32'h200, 32'h0, 4'h0, a, e, d);
      n_assert++; if (d !== 32'h44440200) begin n_fail++; $display("FAIL abort_w0 got %h want 44440200", d); end
      classic(1'b0, 32'h204, 32'h0, 4'h0, a, e, d);
      n_assert++; if (d !== 32'h44440204) begin n_fail++; $display("FAIL abort_w1 got %h want 44440204", d); end
      classic(1'b0, 32'h208, 32'h0, 4'h0, a, e, d);
      n_assert++; if (d !== 32'h33330208) begin n_fail++; $display("FAIL abort_no_wr got %h want 33330208", d); end
      // reset pulse on the second write beat
      drive(1'b1, 1'b1, 1'b1, 32'h300, 32'h55550300, 4'hF, CTI_INCR, BTE_LINEAR);
      tick();
      @(negedge clk);
      n_assert++; if (ack !== 1'b1) begin n_fail++; $display("FAIL rst_burst_b1_ack got %b want 1", ack); end
      tick();
      drive(1'b1, 1'b1, 1'b1, 32'h304, 32'h55550304, 4'hF, CTI_INCR, BTE_LINEAR);
      rst = 1'b1;
      tick();
      rst = 1'b0;
      drive(1'b1, 1'b1, 1'b0, 32'h304, 32'h0, 4'h0, CTI_CLASSIC, BTE_LINEAR);
      @(negedge clk);
      n_assert++; if (ack !== 1'b0) begin n_fail++; $display("FAIL rst_mid_ack got %b want 0", ack); end
      n_assert++; if (err !== 1'b0) begin n_fail++; $display("FAIL rst_mid_err got %b want 0", err); end
      n_assert++; if (rty !== 1'b0) begin n_fail++; $display("FAIL rst_mid_rty got %b want 0", rty); end
      n_assert++; if (dat_r !== 32'h0) begin n_fail++; $display("FAIL rst_mid_dat got %h want 0", dat_r); end
      tick();
      @(negedge clk);
      n_assert++; if (ack !== 1'b1) begin n_fail++; $display("FAIL rst_rd_ack got %b want 1", ack); end
      n_assert++; if (dat_r !== 32'h33330304) begin n_fail++; $display("FAIL rst_no_wr got %h want 33330304", dat_r); end
      tick();
      bus_idle();
      tick();
      classic(1'b0, 32'h300, 32'h0, 4'h0, a, e, d);
      n_assert++; if (d !== 32'h55550300) begin n_fail++; $display("FAIL rst_b1_written got %h want 55550300", d); end
   endtask

   initial begin
      #2000000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

   initial begin
      test_reset();
      test_classic();
      test_byte_enable();
      test_linear_burst();
      test_wrap4();
      test_errors();
      test_abort();
      $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
      $finish;
   end

endmodule
